// File: rtl/sync_fifo_param.sv
// Single-clock parameterised FIFO with occupancy/threshold flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read data; default is registered read data.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  winc,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rinc,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  wfull,
  output logic                  rempty,
  output logic                  half_full,
  output logic                  half_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;

  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] HALF_C  = PW'(DEPTH / 2);
  localparam logic [PW-1:0] AF_C    = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_C    = PW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic                  full_s, empty_s;
  logic                  wr_acc, rd_acc;
  logic [ADDR_WIDTH-1:0] waddr, raddr;

  // All status is decoded from the registered count, so no input reaches a flag combinationally.
  assign full_s  = (count_q == DEPTH_C);
  assign empty_s = (count_q == '0);

  assign waddr = wptr_q[ADDR_WIDTH-1:0];
  assign raddr = rptr_q[ADDR_WIDTH-1:0];

  always_comb begin
    wr_acc      = winc & ~full_s;
    rd_acc      = rinc & ~empty_s;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_acc) wptr_d = wptr_q + PW'(1);
    if (rd_acc) rptr_d = rptr_q + PW'(1);

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + PW'(1);
      2'b01:   count_d = count_q - PW'(1);
      default: count_d = count_q;
    endcase

    // Setting wins over clearing on the same edge.
    if (clr_err)          overflow_d  = 1'b0;
    if (winc && full_s)   overflow_d  = 1'b1;
    if (clr_err)          underflow_d = 1'b0;
    if (rinc && empty_s)  underflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; pointers reset to empty so old words can never be reached.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[waddr] <= wdata;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is visible whenever data is present; masked while empty to hide stale storage.
  assign rdata = empty_s ? '0 : mem_q[raddr];
`else
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (rd_acc) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata_q <= '0;
    else      rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
`endif

  assign wfull        = full_s;
  assign rempty       = empty_s;
  assign half_full    = (count_q >= HALF_C);
  assign half_empty   = (count_q <= HALF_C);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: queue-based reference model, per-cycle compare, directed plus random stimulus.
module tb_sync_fifo_param;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          winc = 1'b0;
  logic          rinc = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          wfull, rempty, half_full, half_empty, almost_full, almost_empty;
  logic [AW:0]   count;
  logic          overflow, underflow;

  sync_fifo_param #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .rinc(rinc), .clr_err(clr_err),
    .rdata(rdata), .wfull(wfull), .rempty(rempty), .half_full(half_full),
    .half_empty(half_empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] q[$];
  logic [DW-1:0] rd_m = '0;
  bit            ovf_m = 1'b0;
  bit            udf_m = 1'b0;
  bit            chk_en = 1'b0;
  int            checks = 0;
  int            errors = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int exp_rdata();
`ifdef SYNC_FIFO_FWFT_EN
    return (q.size() > 0) ? int'(q[0]) : 0;
`else
    return int'(rd_m);
`endif
  endfunction

  function automatic void model_edge(bit w, logic [DW-1:0] d, bit r, bit c);
    int  n = q.size();
    bit  full = (n == DEPTH);
    bit  empty = (n == 0);
    logic [DW-1:0] x;
    if (w && full) ovf_m = 1'b1;
    else if (c)    ovf_m = 1'b0;
    if (r && empty) udf_m = 1'b1;
    else if (c)     udf_m = 1'b0;
    if (r && !empty) begin
      x = q.pop_front();
      rd_m = x;
    end
    if (w && !full) q.push_back(d);
  endfunction

  function automatic void model_reset();
    q.delete();
    rd_m  = '0;
    ovf_m = 1'b0;
    udf_m = 1'b0;
  endfunction

  task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    winc = w; wdata = d; rinc = r; clr_err = c;
    @(posedge clk);
    if (rst) model_edge(w, d, r, c);
    #1;
    winc = 1'b0; rinc = 1'b0; clr_err = 1'b0;
  endtask

  always @(negedge clk) begin : compare
    int n;
    if (chk_en) begin
      n = q.size();
      chk("count",        int'(count),  n);
      chk("wfull",        int'(wfull),  int'(n == DEPTH));
      chk("rempty",       int'(rempty), int'(n == 0));
      chk("half_full",    int'(half_full),    int'(n >= DEPTH / 2));
      chk("half_empty",   int'(half_empty),   int'(n <= DEPTH / 2));
      chk("almost_full",  int'(almost_full),  int'(n >= AF));
      chk("almost_empty", int'(almost_empty), int'(n <= AE));
      chk("overflow",     int'(overflow),  int'(ovf_m));
      chk("underflow",    int'(underflow), int'(udf_m));
      chk("rdata",        int'(rdata),     exp_rdata());
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_count"},  int'(count), 0);
    chk({tag, "_rempty"}, int'(rempty), 1);
    chk({tag, "_wfull"},  int'(wfull), 0);
    chk({tag, "_hempty"}, int'(half_empty), 1);
    chk({tag, "_hfull"},  int'(half_full), 0);
    chk({tag, "_aempty"}, int'(almost_empty), 1);
    chk({tag, "_afull"},  int'(almost_full), 0);
    chk({tag, "_ovf"},    int'(overflow), 0);
    chk({tag, "_udf"},    int'(underflow), 0);
    chk({tag, "_rdata"},  int'(rdata), 0);
  endtask

  task automatic drain();
    for (int k = 0; k < 2 * DEPTH && q.size() > 0; k++) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("por");
    rst = 1'b1;
    chk_en = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      if (i + 1 == 7)  chk("hfull_below", int'(half_full), 0);
      if (i + 1 == 8)  chk("hfull_at_8", int'(half_full), 1);
      if (i + 1 == 11) chk("afull_below", int'(almost_full), 0);
      if (i + 1 == 12) chk("afull_at_12", int'(almost_full), 1);
    end
    chk("fill_count", int'(count), 16);
    chk("fill_wfull", int'(wfull), 1);

    step(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_count", int'(count), 16);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("ovf_clr", int'(overflow), 0);

    for (int i = 0; i < DEPTH; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      chk("rd_order", int'(rdata), i);
`endif
      step(1'b0, '0, 1'b1, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
      chk("rd_order", int'(rdata), i);
`endif
      if (DEPTH - 1 - i == 5) chk("aempty_above", int'(almost_empty), 0);
      if (DEPTH - 1 - i == 4) chk("aempty_at_4", int'(almost_empty), 1);
    end
    chk("drain_rempty", int'(rempty), 1);

    step(1'b0, '0, 1'b1, 1'b0);
    chk("udf_set", int'(underflow), 1);
    chk("udf_count", int'(count), 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("udf_rdata_hold", int'(rdata), 15);
`endif
    step(1'b0, '0, 1'b0, 1'b1);
    chk("udf_clr", int'(underflow), 0);

    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(100 + i), 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    chk("sim_full_count", int'(count), 15);
    chk("sim_full_ovf", int'(overflow), 1);
    step(1'b0, '0, 1'b0, 1'b1);
    drain();
    step(1'b1, 8'h66, 1'b1, 1'b0);
    chk("sim_empty_count", int'(count), 1);
    chk("sim_empty_udf", int'(underflow), 1);
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 8'(i + 200), 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    chk("sim_mid_count", int'(count), 5);
    drain();

    for (int k = 0; k < 40; k++) begin
      step(1'b1, 8'(8'h80 + k), k >= 3, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
      if (k >= 3) chk("stream_order", int'(rdata), 8'h80 + k - 3);
`endif
    end
    drain();

    for (int cyc = 0; cyc < 3000; cyc++) begin
      int wp;
      case ((cyc / 150) % 3)
        0:       wp = 75;
        1:       wp = 25;
        default: wp = 50;
      endcase
      step($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < (100 - wp),
           $urandom_range(0, 31) == 0);
    end

    drain();
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 8'(i + 8'h30), 1'b0, 1'b0);
    chk("pre_rst_count", int'(count), 7);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    check_reset_values("mid_rst");
    step(1'b1, 8'h99, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("post_rst_count", int'(count), 1);
`ifdef SYNC_FIFO_FWFT_EN
    chk("post_rst_rdata", int'(rdata), 8'hA5);
`endif
    step(1'b0, '0, 1'b1, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("post_rst_rdata", int'(rdata), 8'hA5);
`endif
    chk("post_rst_empty", int'(rempty), 1);

    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
